// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: round-robin grant of N_REQ requesters onto one registered
// register-file write port, plus a pending-destination scoreboard for hazard checks.
module reg_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int N_REQ = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [5*N_REQ-1:0]    req_addr,
    input  logic [XLEN*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  alloc_valid,
    input  logic [4:0]            alloc_addr,
    input  logic                  flush,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_wren,
    output logic [4:0]            rd_addr,
    output logic [XLEN-1:0]       rd_data
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]        ptr;
    logic [PW-1:0]        ptr_next;
    logic [31:0]          pend;
    logic [31:0]          pend_next;

    logic [2*N_REQ-1:0]   dbl;
    logic [PW:0]          sum;
    logic                 found;
    logic                 xfer;
    logic [PW-1:0]        gnt_idx;
    logic [4:0]           gnt_addr;
    logic [XLEN-1:0]      gnt_data;

    // Rotating the doubled request vector by ptr turns the round-robin scan
    // into a plain lowest-set-bit search.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        dbl      = {req_valid, req_valid} >> ptr;
        found    = 1'b0;
        sum      = '0;
        gnt_addr = '0;
        gnt_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && dbl[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (PW+1)'(k);
            end
        end
        if (sum >= (PW+1)'(N_REQ)) begin
            sum = sum - (PW+1)'(N_REQ);
        end
        gnt_idx  = sum[PW-1:0];
        xfer     = found && rst_n;
        ptr_next = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;

        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                gnt_addr     = req_addr[5*i +: 5];
                gnt_data     = req_data[XLEN*i +: XLEN];
                req_ready[i] = xfer;
            end
        end
    end

    // Alloc is applied after commit so a same-cycle alloc of the committing
    // register leaves it pending; flush overrides both.
    always_comb begin
        pend_next = pend;
        if (rd_wren) begin
            pend_next[rd_addr] = 1'b0;
        end
        if (alloc_valid) begin
            pend_next[alloc_addr] = 1'b1;
        end
        if (flush) begin
            pend_next = '0;
        end
        pend_next[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= '0;
            pend    <= '0;
            rd_wren <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            if (xfer) begin
                ptr     <= ptr_next;
                rd_addr <= gnt_addr;
                rd_data <= gnt_data;
            end
            // Writes to x0 are accepted but never reach the register file.
            rd_wren <= xfer && (gnt_addr != 5'd0);
            pend    <= pend_next;
        end
    end

    assign rs1_busy = pend[rs1_addr];
    assign rs2_busy = pend[rs2_addr];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: table-driven arbitration vectors with a
// queue scoreboard for the write port, then hand-written scoreboard/flush/reset sequences.
module tb_reg_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int N_REQ = 3;

    logic                  clk;
    logic                  rst_n;
    logic [N_REQ-1:0]      req_valid;
    logic [5*N_REQ-1:0]    req_addr;
    logic [XLEN*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  alloc_valid;
    logic [4:0]            alloc_addr;
    logic                  flush;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  rd_wren;
    logic [4:0]            rd_addr;
    logic [XLEN-1:0]       rd_data;

    reg_wb_arbiter #(.XLEN(XLEN), .N_REQ(N_REQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_wren     (rd_wren),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic        wren;
        logic        chk_ad;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    logic        ad_known  = 1'b1;

    function automatic vec_t mk(input logic [2:0] valid, input logic [4:0] a2, input logic [4:0] a1,
                                input logic [4:0] a0, input logic [31:0] dbase, input logic [2:0] exp_ready);
        vec_t v;
        v.valid     = valid;
        v.addr      = {a2, a1, a0};
        v.data      = {dbase + 32'd2, dbase + 32'd1, dbase};
        v.exp_ready = exp_ready;
        return v;
    endfunction

    task automatic apply(input int k);
        vec_t        v;
        exp_t        e;
        int          g;
        logic [4:0]  ga;
        logic [31:0] gd;
        v = vecs[k];
        g = -1;
        @(negedge clk);
        req_valid = v.valid;
        req_addr  = v.addr;
        req_data  = v.data;
        #1;
        check($sformatf("ready[%0d]", k), 32'(req_ready), 32'(v.exp_ready));
        for (int i = 0; i < N_REQ; i++) begin
            if (v.exp_ready[i] && v.valid[i]) g = i;
        end
        e.wren = 1'b0;
        if (g >= 0) begin
            ga = v.addr[5*g +: 5];
            gd = v.data[32*g +: 32];
            e.wren = (ga != 5'd0);
            if (ga != 5'd0) begin
                last_addr = ga;
                last_data = gd;
                ad_known  = 1'b1;
            end else begin
                ad_known  = 1'b0;
            end
        end
        e.chk_ad = ad_known;
        e.addr   = last_addr;
        e.data   = last_data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("wren[%0d]", k), 32'(rd_wren), 32'(e.wren));
        if (e.chk_ad) begin
            check($sformatf("addr[%0d]", k), 32'(rd_addr), 32'(e.addr));
            check($sformatf("data[%0d]", k), rd_data, e.data);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(3'b111, 5'd3,  5'd2,  5'd1,  32'h1000_0000, 3'b001);
        vecs[1]  = mk(3'b111, 5'd6,  5'd5,  5'd4,  32'h2000_0000, 3'b010);
        vecs[2]  = mk(3'b111, 5'd9,  5'd8,  5'd7,  32'h3000_0000, 3'b100);
        vecs[3]  = mk(3'b111, 5'd12, 5'd11, 5'd10, 32'h4000_0000, 3'b001);
        vecs[4]  = mk(3'b111, 5'd15, 5'd14, 5'd13, 32'h5000_0000, 3'b010);
        vecs[5]  = mk(3'b111, 5'd18, 5'd17, 5'd16, 32'h6000_0000, 3'b100);
        vecs[6]  = mk(3'b010, 5'd0,  5'd5,  5'd0,  32'hDEAD_BEEE, 3'b010);
        vecs[7]  = mk(3'b001, 5'd0,  5'd0,  5'd0,  32'h7000_0000, 3'b001);
        vecs[8]  = mk(3'b101, 5'd21, 5'd0,  5'd20, 32'h8000_0000, 3'b100);
        vecs[9]  = mk(3'b000, 5'd0,  5'd0,  5'd0,  32'h0000_0000, 3'b000);
        vecs[10] = mk(3'b011, 5'd0,  5'd23, 5'd22, 32'h9000_0000, 3'b001);
        vecs[11] = mk(3'b110, 5'd29, 5'd28, 5'd0,  32'hA000_0000, 3'b010);

        rst_n       = 1'b0;
        req_valid   = 3'b111;
        req_addr    = '0;
        req_data    = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        flush       = 1'b0;
        rs1_addr    = 5'd7;
        rs2_addr    = 5'd0;

        // Reset state
        @(negedge clk);
        #1;
        check("ready_in_reset", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        check("rst_wren", 32'(rd_wren), 32'h0);
        check("rst_addr", 32'(rd_addr), 32'h0);
        check("rst_data", rd_data, 32'h0);
        check("rst_busy", 32'(rs1_busy), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;

        for (int k = 0; k < 12; k++) apply(k);

        // Scoreboard: alloc, commit, then alloc colliding with commit
        @(negedge clk);
        req_valid   = '0;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        rs1_addr    = 5'd7;
        #1;
        check("busy_no_bypass", 32'(rs1_busy), 32'h0);
        @(posedge clk);
        #1;
        check("alloc7_busy", 32'(rs1_busy), 32'h1);
        @(negedge clk);
        alloc_valid = 1'b0;
        req_valid   = 3'b001;
        req_addr    = 15'd7;
        req_data    = {64'h0, 32'hCAFE_0007};
        #1;
        check("alu_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("commit7_wren", 32'(rd_wren), 32'h1);
        check("commit7_addr", 32'(rd_addr), 32'h7);
        check("busy_during_wren", 32'(rs1_busy), 32'h1);
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        #1;
        check("busy_cleared", 32'(rs1_busy), 32'h0);
        check("wren_idle", 32'(rd_wren), 32'h0);

        @(negedge clk);
        alloc_valid = 1'b1;
        @(posedge clk);
        #1;
        check("realloc7_busy", 32'(rs1_busy), 32'h1);
        @(negedge clk);
        alloc_valid = 1'b0;
        req_valid   = 3'b001;
        @(posedge clk);
        #1;
        check("commit7b_wren", 32'(rd_wren), 32'h1);
        @(negedge clk);
        req_valid   = '0;
        alloc_valid = 1'b1;
        @(posedge clk);
        #1;
        check("alloc_wins", 32'(rs1_busy), 32'h1);
        @(negedge clk);
        alloc_valid = 1'b0;
        @(posedge clk);
        #1;
        check("alloc_wins_hold", 32'(rs1_busy), 32'h1);

        // Flush with pending {3,7,9} and a simultaneous alloc of 4
        @(negedge clk);
        alloc_valid = 1'b1;
        alloc_addr  = 5'd3;
        @(negedge clk);
        alloc_addr  = 5'd9;
        @(negedge clk);
        alloc_valid = 1'b0;
        rs1_addr    = 5'd3;
        rs2_addr    = 5'd9;
        #1;
        check("pend3", 32'(rs1_busy), 32'h1);
        check("pend9", 32'(rs2_busy), 32'h1);
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr  = 5'd4;
        @(posedge clk);
        #1;
        check("flush3", 32'(rs1_busy), 32'h0);
        check("flush9", 32'(rs2_busy), 32'h0);
        @(negedge clk);
        flush       = 1'b0;
        alloc_valid = 1'b0;
        rs1_addr    = 5'd4;
        rs2_addr    = 5'd7;
        #1;
        check("flush4", 32'(rs1_busy), 32'h0);
        check("flush7", 32'(rs2_busy), 32'h0);

        // Reset in the cycle after a transfer
        @(negedge clk);
        req_valid = 3'b010;
        req_addr  = {5'd0, 5'd12, 5'd0};
        req_data  = {32'h0, 32'h1234_5678, 32'h0};
        @(posedge clk);
        #1;
        check("pre_reset_wren", 32'(rd_wren), 32'h1);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 3'b111;
        #1;
        check("ready_reset_held", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        check("reset_drops_wren", 32'(rd_wren), 32'h0);
        check("reset_addr", 32'(rd_addr), 32'h0);
        @(negedge clk);
        #1;
        check("ready_reset_held2", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_grant_after_reset", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the register write port.
REQ-002 SHALL have parameter N_REQ, default 3, number of writeback requesters (0=ALU, 1=LSU, 2=MDU); legal range 2..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester write request.
REQ-006 SHALL have port req_addr  input  5*N_REQ  per-requester destination register; slice i = bits [5i+4:5i].
REQ-007 SHALL have port req_data  input  XLEN*N_REQ  per-requester write data; slice i = bits [XLEN*i+XLEN-1:XLEN*i].
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have port alloc_valid  input  1  decode marks a destination as pending.
REQ-010 SHALL have port alloc_addr  input  5  destination being allocated.
REQ-011 SHALL have port flush  input  1  clears all pending marks.
REQ-012 SHALL have port rs1_addr  input  5  and port rs2_addr  input  5, source registers to check.
REQ-013 SHALL have port rs1_busy  output  1  and port rs2_busy  output  1, pending-write status for the sources.
REQ-014 SHALL have port rd_wren  output  1, port rd_addr  output  5 and port rd_data  output  XLEN: the registered register-file write port.

Function
REQ-015 SHALL grant at most one requester per cycle: a transfer on requester i occurs when req_valid[i] and req_ready[i] are both high.
REQ-016 SHALL make req_ready combinational from req_valid and the round-robin pointer ptr. req_ready[i] SHALL be high only for the first valid requester found scanning i = ptr, ptr+1, ... modulo N_REQ.
REQ-017 SHALL, on a transfer from requester g, set ptr to (g+1) mod N_REQ on the next edge; ptr SHALL hold when no transfer occurs.
REQ-018 SHALL register the granted request: the cycle after a transfer, rd_wren=1, rd_addr=req_addr[g] and rd_data=req_data[g], for exactly one cycle.
REQ-019 SHALL drive rd_wren=0 in any cycle after a cycle with no transfer; rd_addr and rd_data SHALL hold their last values.
REQ-020 SHALL accept a transfer with req_addr=0 (ready asserted, ptr advances), but SHALL drive rd_wren=0 in the following cycle.
REQ-021 SHALL keep a 32-bit pending mask pend; bit 0 SHALL always read 0.
REQ-022 SHALL set pend[alloc_addr] on the next edge when alloc_valid=1 and alloc_addr!=0.
REQ-023 SHALL clear pend[a] on the edge on which rd_wren=1 and rd_addr=a (commit).
REQ-024 SHALL leave pend[a] set when alloc and commit target the same address a in the same cycle (alloc wins).
REQ-025 SHALL clear all of pend when flush=1, ignoring a simultaneous alloc and commit; an rd_wren already registered SHALL still be driven.
REQ-026 SHALL compute rs1_busy = pend[rs1_addr] and rs2_busy = pend[rs2_addr] combinationally from the registered mask, with no bypass of same-cycle alloc or commit.
REQ-027 SHALL hold pend, ptr and the output registers unchanged when all req_valid=0, alloc_valid=0 and flush=0.
REQ-028 SHALL have a transfer-to-write latency of 1 cycle, and a commit-to-busy-clear latency of 1 cycle after rd_wren.

Reset
REQ-029 SHALL, on the edge with rst_n=0, set rd_wren=0, rd_addr=0, rd_data=0, ptr=0 and pend=0.
REQ-030 SHALL force req_ready=0 while rst_n=0, regardless of req_valid.
REQ-031 SHALL discard any in-flight write on reset: rd_wren SHALL be 0 in the cycle after a reset edge, even if a transfer occurred in the preceding cycle.

Verification
REQ-032 Round-robin: after reset, hold req_valid=3'b111 for 6 cycles -> grants 0,1,2,0,1,2; rd_wren=1 on cycles 2..7 with the matching rd_addr and rd_data.
REQ-033 Single requester: req_valid=3'b010, req_addr[1]=5, req_data[1]=32'hDEADBEEF -> req_ready=3'b010 the same cycle; next cycle rd_wren=1, rd_addr=5, rd_data=32'hDEADBEEF; ptr=2.
REQ-034 x0 write: req_valid[0]=1, req_addr[0]=0 -> req_ready[0]=1; next cycle rd_wren=0; ptr=1.
REQ-035 Scoreboard: alloc rd=7, then rs1_addr=7 -> rs1_busy=1 the next cycle. ALU writes 7 -> rs1_busy=0 the cycle after rd_wren. Alloc 7 issued in the same cycle as the commit of 7 -> rs1_busy stays 1.
REQ-036 Flush: pend={3,9}, then flush=1 with alloc_addr=4 -> next cycle pend=0 and rs1_busy=0 for addresses 3, 4 and 9.
REQ-037 Reset mid-operation: transfer in cycle n, rst_n=0 in cycle n+1 -> rd_wren=0 in cycle n+2, req_ready=0 while reset is held, and after release the first grant goes to requester 0.
